// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM states, frame geometry and the
// prefix bytes the downstream keyboard controller also decodes.
`timescale 1ns/1ps
package ps2_pkg;
   localparam int DATA_BITS = 8;
   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXTEND = 8'hE0;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer, run-length glitch filter and falling-edge pulse
// for one raw PS/2 line.
`timescale 1ns/1ps
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic pin,
   output logic fall
);
   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic             sync_p0, sync_p1;
   logic             level, level_q;
   logic [CNT_W-1:0] run_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         level   <= 1'b1;
         level_q <= 1'b1;
         run_cnt <= '0;
      end else begin
         sync_p0 <= pin;
         sync_p1 <= sync_p0;
         level_q <= level;
         // Any sample matching the current level restarts the run.
         if (sync_p1 == level) begin
            run_cnt <= '0;
         end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
            level   <= sync_p1;
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + CNT_W'(1);
         end
      end
   end

   assign fall = level_q & ~level;
endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: frames 11-bit PS/2 packets into scancodes
// with valid / parity_err / frame_err strobes and an inter-bit timeout.
`timescale 1ns/1ps
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic [7:0] scancode,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err
);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BIT_W = $clog2(DATA_BITS);

   logic             clk_fall;
   logic             data_p0, data_p1;
   ps2_state_t       state, state_nx;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_nx;
   logic [TO_W-1:0]  to_cnt, to_cnt_nx;
   logic [7:0]       shreg, shreg_nx;
   logic             par_bit, par_nx;
   logic [7:0]       scancode_nx;
   logic             valid_nx, perr_nx, ferr_nx;
   logic             timeout;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clock (clock),
      .reset (reset),
      .pin   (ps2_clock),
      .fall  (clk_fall)
   );

   // Fires as the counter would step onto TIMEOUT_CYCLES, so the registered
   // error lands exactly TIMEOUT_CYCLES after the point a valid would have.
   assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nx    = state;
      bit_cnt_nx  = bit_cnt;
      shreg_nx    = shreg;
      par_nx      = par_bit;
      scancode_nx = scancode;
      to_cnt_nx   = '0;
      valid_nx    = 1'b0;
      perr_nx     = 1'b0;
      ferr_nx     = 1'b0;

      if (state != IDLE) to_cnt_nx = clk_fall ? '0 : to_cnt + TO_W'(1);

      case (state)
         IDLE: begin
            if (clk_fall && !data_p1) begin
               state_nx   = DATA;
               bit_cnt_nx = '0;
               shreg_nx   = '0;
            end
         end
         DATA: begin
            if (clk_fall) begin
               shreg_nx   = {data_p1, shreg[7:1]};
               bit_cnt_nx = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_nx = PARITY;
            end
         end
         PARITY: begin
            if (clk_fall) begin
               par_nx   = data_p1;
               state_nx = STOP;
            end
         end
         STOP: begin
            // A bad stop bit outranks a parity failure.
            if (clk_fall) begin
               state_nx = IDLE;
               if (!data_p1) begin
                  ferr_nx = 1'b1;
               end else if (~^{shreg, par_bit}) begin
                  perr_nx = 1'b1;
               end else begin
                  valid_nx    = 1'b1;
                  scancode_nx = shreg;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      if (state != IDLE && !clk_fall && timeout) begin
         state_nx  = IDLE;
         ferr_nx   = 1'b1;
         to_cnt_nx = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         scancode   <= 8'h00;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         data_p0    <= 1'b1;
         data_p1    <= 1'b1;
      end else begin
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         to_cnt     <= to_cnt_nx;
         scancode   <= scancode_nx;
         valid      <= valid_nx;
         parity_err <= perr_nx;
         frame_err  <= ferr_nx;
         data_p0    <= ps2_data;
         data_p1    <= data_p0;
      end
   end

   always_ff @(posedge clock) begin
      shreg   <= shreg_nx;
      par_bit <= par_nx;
   end
endmodule
